// File: rtl/ctrl_pipe.sv
// ctrl_pipe: receiving end of the decode-stage control bundle.
//   Carries decoded control and register specifiers through ID/EX, EX/MEM
//   and MEM/WB, detects load-use and branch-compare hazards, and produces
//   stall / bubble / fetch-flush / forwarding selects. Counts bubbles.
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   *_d, flush_d, rs/rt/rd_d   decode-stage control and specifiers
//   *_e, rs_e, rt_e            EX-stage control and sources
//   writereg_e/m/w             destination register per stage
//   *_m, *_w                   MEM / WB control
//   stall_f, stall_d, flush_f  fetch/decode hold and IF/ID clear
//   forward_ae/be              EX operand select: 00 regfile, 01 WB, 10 MEM
//   forward_ad/bd              ID branch-compare operand from MEM
//   bubble_cnt                 saturating count of inserted bubbles

// Per-operand forwarding select; one instance per source operand (rs, rt).
module ctrl_pipe_fwd (
    input  logic [4:0] src_e,
    input  logic [4:0] src_d,
    input  logic       regwrite_m,
    input  logic [4:0] writereg_m,
    input  logic       regwrite_w,
    input  logic [4:0] writereg_w,
    output logic [1:0] fwd_e,
    output logic       fwd_d
);
    logic hit_m_e, hit_w_e;

    // $zero is never a forwarding source.
    assign hit_m_e = regwrite_m && (writereg_m != 5'd0) && (writereg_m == src_e);
    assign hit_w_e = regwrite_w && (writereg_w != 5'd0) && (writereg_w == src_e);

    // MEM holds the younger result, so it wins over WB.
    assign fwd_e = hit_m_e ? 2'b10 : (hit_w_e ? 2'b01 : 2'b00);
    assign fwd_d = regwrite_m && (writereg_m != 5'd0) && (writereg_m == src_d);
endmodule

module ctrl_pipe #(
    parameter int CNT_W    = 16,
    parameter int LINK_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memtoreg_d,
    input  logic             memwrite_d,
    input  logic             regwrite_d,
    input  logic             regdst_d,
    input  logic             alusrc_d,
    input  logic             jal_d,
    input  logic             branch_d,
    input  logic [2:0]       alucontrol_d,
    input  logic             flush_d,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rd_d,
    output logic             memtoreg_e,
    output logic             memwrite_e,
    output logic             regwrite_e,
    output logic             alusrc_e,
    output logic             jal_e,
    output logic [2:0]       alucontrol_e,
    output logic [4:0]       rs_e,
    output logic [4:0]       rt_e,
    output logic [4:0]       writereg_e,
    output logic [4:0]       writereg_m,
    output logic [4:0]       writereg_w,
    output logic             memtoreg_m,
    output logic             memwrite_m,
    output logic             regwrite_m,
    output logic             memtoreg_w,
    output logic             regwrite_w,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_f,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             forward_ad,
    output logic             forward_bd,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       jal;
        logic [2:0] alucontrol;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } idex_t;

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic [4:0] writereg;
    } exmem_t;

    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] writereg;
    } memwb_t;

    idex_t  id_in, ex_q;
    exmem_t mem_q;
    memwb_t wb_q;

    logic lwstall, branchstall, stall;

    always_comb begin
        id_in            = '0;
        id_in.memtoreg   = memtoreg_d;
        id_in.memwrite   = memwrite_d;
        id_in.regwrite   = regwrite_d;
        id_in.regdst     = regdst_d;
        id_in.alusrc     = alusrc_d;
        id_in.jal        = jal_d;
        id_in.alucontrol = alucontrol_d;
        id_in.rs         = rs_d;
        id_in.rt         = rt_d;
        id_in.rd         = rd_d;
    end

    // EX-stage view
    assign memtoreg_e   = ex_q.memtoreg;
    assign memwrite_e   = ex_q.memwrite;
    assign regwrite_e   = ex_q.regwrite;
    assign alusrc_e     = ex_q.alusrc;
    assign jal_e        = ex_q.jal;
    assign alucontrol_e = ex_q.alucontrol;
    assign rs_e         = ex_q.rs;
    assign rt_e         = ex_q.rt;
    assign writereg_e   = ex_q.jal ? 5'(LINK_REG) : (ex_q.regdst ? ex_q.rd : ex_q.rt);

    // MEM / WB view
    assign memtoreg_m = mem_q.memtoreg;
    assign memwrite_m = mem_q.memwrite;
    assign regwrite_m = mem_q.regwrite;
    assign writereg_m = mem_q.writereg;
    assign memtoreg_w = wb_q.memtoreg;
    assign regwrite_w = wb_q.regwrite;
    assign writereg_w = wb_q.writereg;

    // Load-use is deliberately not gated on $zero: a spurious stall is harmless.
    assign lwstall = memtoreg_e && regwrite_e && ((rt_e == rs_d) || (rt_e == rt_d));

    // Branch compares in ID, so an operand still being produced in EX, or a
    // load result still in MEM, must be waited on.
    assign branchstall = branch_d &&
        ((regwrite_e && ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
         (memtoreg_m && ((writereg_m == rs_d) || (writereg_m == rt_d))));

    assign stall   = lwstall || branchstall;
    assign stall_f = stall;
    assign stall_d = stall;
    // A branch outcome computed from pending operands is not trustworthy.
    assign flush_f = flush_d && !stall;

    // Forwarding: index 0 is the rs operand, index 1 is rt.
    logic [1:0][4:0] src_e, src_d;
    logic [1:0][1:0] fwd_e;
    logic [1:0]      fwd_d;

    assign src_e = {rt_e, rs_e};
    assign src_d = {rt_d, rs_d};

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        ctrl_pipe_fwd u_fwd (
            .src_e      (src_e[i]),
            .src_d      (src_d[i]),
            .regwrite_m (mem_q.regwrite),
            .writereg_m (mem_q.writereg),
            .regwrite_w (wb_q.regwrite),
            .writereg_w (wb_q.writereg),
            .fwd_e      (fwd_e[i]),
            .fwd_d      (fwd_d[i])
        );
    end

    assign forward_ae = fwd_e[0];
    assign forward_be = fwd_e[1];
    assign forward_ad = fwd_d[0];
    assign forward_bd = fwd_d[1];

    // ID/EX takes a bubble on stall; EX/MEM and MEM/WB always advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            bubble_cnt <= '0;
        end else begin
            ex_q           <= stall ? '0 : id_in;
            mem_q.memtoreg <= ex_q.memtoreg;
            mem_q.memwrite <= ex_q.memwrite;
            mem_q.regwrite <= ex_q.regwrite;
            mem_q.writereg <= writereg_e;
            wb_q.memtoreg  <= mem_q.memtoreg;
            wb_q.regwrite  <= mem_q.regwrite;
            wb_q.writereg  <= mem_q.writereg;
            if (stall && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a default instance plus a CNT_W=4 instance
// sharing the same stimulus, so counter saturation can be observed.
module tb_ctrl_pipe;
    logic       clk, reset;
    logic       memtoreg_d, memwrite_d, regwrite_d, regdst_d, alusrc_d, jal_d, branch_d, flush_d;
    logic [2:0] alucontrol_d;
    logic [4:0] rs_d, rt_d, rd_d;

    logic       memtoreg_e, memwrite_e, regwrite_e, alusrc_e, jal_e;
    logic [2:0] alucontrol_e;
    logic [4:0] rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic       memtoreg_m, memwrite_m, regwrite_m, memtoreg_w, regwrite_w;
    logic       stall_f, stall_d, flush_f, forward_ad, forward_bd;
    logic [1:0] forward_ae, forward_be;
    logic [15:0] bubble_cnt;

    logic       s_memtoreg_e, s_memwrite_e, s_regwrite_e, s_alusrc_e, s_jal_e;
    logic [2:0] s_alucontrol_e;
    logic [4:0] s_rs_e, s_rt_e, s_writereg_e, s_writereg_m, s_writereg_w;
    logic       s_memtoreg_m, s_memwrite_m, s_regwrite_m, s_memtoreg_w, s_regwrite_w;
    logic       s_stall_f, s_stall_d, s_flush_f, s_forward_ad, s_forward_bd;
    logic [1:0] s_forward_ae, s_forward_be;
    logic [3:0] s_bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;

    ctrl_pipe dut (
        .clk(clk), .reset(reset),
        .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d), .regwrite_d(regwrite_d),
        .regdst_d(regdst_d), .alusrc_d(alusrc_d), .jal_d(jal_d), .branch_d(branch_d),
        .alucontrol_d(alucontrol_d), .flush_d(flush_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e), .regwrite_e(regwrite_e),
        .alusrc_e(alusrc_e), .jal_e(jal_e), .alucontrol_e(alucontrol_e),
        .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
        .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m), .regwrite_m(regwrite_m),
        .memtoreg_w(memtoreg_w), .regwrite_w(regwrite_w),
        .stall_f(stall_f), .stall_d(stall_d), .flush_f(flush_f),
        .forward_ae(forward_ae), .forward_be(forward_be),
        .forward_ad(forward_ad), .forward_bd(forward_bd),
        .bubble_cnt(bubble_cnt)
    );

    ctrl_pipe #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset),
        .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d), .regwrite_d(regwrite_d),
        .regdst_d(regdst_d), .alusrc_d(alusrc_d), .jal_d(jal_d), .branch_d(branch_d),
        .alucontrol_d(alucontrol_d), .flush_d(flush_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .memtoreg_e(s_memtoreg_e), .memwrite_e(s_memwrite_e), .regwrite_e(s_regwrite_e),
        .alusrc_e(s_alusrc_e), .jal_e(s_jal_e), .alucontrol_e(s_alucontrol_e),
        .rs_e(s_rs_e), .rt_e(s_rt_e),
        .writereg_e(s_writereg_e), .writereg_m(s_writereg_m), .writereg_w(s_writereg_w),
        .memtoreg_m(s_memtoreg_m), .memwrite_m(s_memwrite_m), .regwrite_m(s_regwrite_m),
        .memtoreg_w(s_memtoreg_w), .regwrite_w(s_regwrite_w),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .flush_f(s_flush_f),
        .forward_ae(s_forward_ae), .forward_be(s_forward_be),
        .forward_ad(s_forward_ad), .forward_bd(s_forward_bd),
        .bubble_cnt(s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 2 time units past it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_d(input logic mtr, input logic mw, input logic rw, input logic rdst,
                         input logic asrc, input logic jl, input logic br, input logic fl,
                         input logic [2:0] ac, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        memtoreg_d = mtr; memwrite_d = mw; regwrite_d = rw; regdst_d = rdst;
        alusrc_d = asrc; jal_d = jl; branch_d = br; flush_d = fl;
        alucontrol_d = ac; rs_d = rs; rt_d = rt; rd_d = rd;
    endtask

    initial begin
        reset = 1'b0;
        set_d(0,0,0,0,0,0,0,0, 3'b000, 5'd0, 5'd0, 5'd0);

        // Reset state
        tick();
        chk("rst_regwrite_m", regwrite_m, 0);
        chk("rst_writereg_w", writereg_w, 0);
        chk("rst_alucontrol_e", alucontrol_e, 0);
        chk("rst_bubble_cnt", bubble_cnt, 0);
        chk("rst_stall", stall_f, 0);
        chk("rst_fwd_ae", forward_ae, 0);
        reset = 1'b1;

        // Load-use: lw rt=5 followed by a consumer of r5
        set_d(1,0,1,0,1,0,0,0, 3'b010, 5'd1, 5'd5, 5'd0);
        #1 chk("lu_no_stall_empty_ex", stall_f, 0);
        tick();
        set_d(0,0,1,1,0,0,0,0, 3'b010, 5'd5, 5'd6, 5'd7);
        #1;
        chk("lu_stall_f", stall_f, 1);
        chk("lu_stall_d", stall_d, 1);
        chk("lu_writereg_e", writereg_e, 5);
        chk("lu_cnt0", bubble_cnt, 0);
        tick();
        chk("lu_bubble_regwrite_e", regwrite_e, 0);
        chk("lu_bubble_memwrite_e", memwrite_e, 0);
        chk("lu_bubble_memtoreg_e", memtoreg_e, 0);
        chk("lu_cnt1", bubble_cnt, 1);
        chk("lu_stall_cleared", stall_f, 0);
        chk("lu_writereg_m", writereg_m, 5);
        chk("lu_memtoreg_m", memtoreg_m, 1);
        chk("lu_fwd_ad", forward_ad, 1);
        tick();
        chk("lu_rs_e", rs_e, 5);
        chk("lu_writereg_e_add", writereg_e, 7);
        chk("lu_writereg_w", writereg_w, 5);
        chk("lu_memtoreg_w", memtoreg_w, 1);
        chk("lu_fwd_ae_wb", forward_ae, 2'b01);
        chk("lu_fwd_be_none", forward_be, 2'b00);

        // EX forwarding, MEM and WB both hold r7: MEM wins
        set_d(0,0,1,1,0,0,0,0, 3'b010, 5'd1, 5'd2, 5'd7); tick();
        set_d(0,0,1,1,0,0,0,0, 3'b010, 5'd2, 5'd3, 5'd7); tick();
        set_d(0,0,1,1,0,0,0,0, 3'b010, 5'd7, 5'd7, 5'd8); tick();
        chk("fw_ae_mem", forward_ae, 2'b10);
        chk("fw_be_mem", forward_be, 2'b10);

        // MEM instruction targets r7 but does not write: WB is used
        set_d(0,0,1,1,0,0,0,0, 3'b010, 5'd1, 5'd2, 5'd7); tick();
        set_d(0,1,0,1,0,0,0,0, 3'b010, 5'd2, 5'd3, 5'd7); tick();
        set_d(0,0,1,1,0,0,0,0, 3'b010, 5'd7, 5'd7, 5'd8); tick();
        chk("fw_ae_wb", forward_ae, 2'b01);
        chk("fw_be_wb", forward_be, 2'b01);
        chk("fw_regwrite_m0", regwrite_m, 0);

        // Writes to $zero never forward
        set_d(0,0,1,1,0,0,0,0, 3'b010, 5'd1, 5'd2, 5'd0); tick();
        set_d(0,0,1,1,0,0,0,0, 3'b010, 5'd1, 5'd2, 5'd0); tick();
        set_d(0,0,0,0,0,0,0,0, 3'b010, 5'd0, 5'd0, 5'd0); tick();
        chk("fw_ae_zero", forward_ae, 2'b00);
        chk("fw_be_zero", forward_be, 2'b00);

        // Branch on r3 right behind its producer
        set_d(0,0,1,1,0,0,0,0, 3'b010, 5'd1, 5'd2, 5'd3); tick();
        set_d(0,0,0,0,0,0,1,1, 3'b001, 5'd3, 5'd4, 5'd0);
        #1;
        chk("br_stall", stall_f, 1);
        chk("br_stall_d", stall_d, 1);
        chk("br_flush_blocked", flush_f, 0);
        tick();
        chk("br_stall_cleared", stall_f, 0);
        chk("br_writereg_m", writereg_m, 3);
        chk("br_fwd_ad", forward_ad, 1);
        chk("br_fwd_bd", forward_bd, 0);
        chk("br_flush", flush_f, 1);
        chk("br_cnt2", bubble_cnt, 2);

        // jal forces the link register through all stages
        set_d(0,0,1,0,0,1,0,0, 3'b000, 5'd0, 5'd0, 5'd9); tick();
        chk("jal_writereg_e", writereg_e, 31);
        chk("jal_e", jal_e, 1);
        set_d(0,0,0,0,0,0,0,0, 3'b000, 5'd0, 5'd0, 5'd0); tick();
        chk("jal_writereg_m", writereg_m, 31);
        tick();
        chk("jal_writereg_w", writereg_w, 31);
        chk("jal_regwrite_w", regwrite_w, 1);

        // Asynchronous reset mid-stream
        set_d(0,0,1,1,0,0,0,0, 3'b010, 5'd1, 5'd2, 5'd10); tick();
        set_d(0,0,0,0,0,0,0,0, 3'b000, 5'd0, 5'd0, 5'd0); tick();
        chk("mr_pre_regwrite_m", regwrite_m, 1);
        chk("mr_pre_writereg_m", writereg_m, 10);
        #1 reset = 1'b0;
        #1;
        chk("mr_regwrite_m", regwrite_m, 0);
        chk("mr_writereg_m", writereg_m, 0);
        chk("mr_writereg_w", writereg_w, 0);
        chk("mr_regwrite_w", regwrite_w, 0);
        chk("mr_bubble_cnt", bubble_cnt, 0);
        chk("mr_s_bubble_cnt", s_bubble_cnt, 0);

        // Repeated load-use: stalls every other cycle, 20 bubbles in 40 edges
        #1;
        set_d(1,0,1,0,1,0,0,0, 3'b010, 5'd5, 5'd5, 5'd0);
        reset = 1'b1;
        #1 chk("post_rst_no_hazard", stall_f, 0);
        repeat (40) tick();
        chk("sat_cnt16", bubble_cnt, 20);
        chk("sat_cnt4", s_bubble_cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
